// File: rtl/axi_pkg.sv
// Shared AXI write/read front-end types: burst and response encodings, write FSM states
// and width helpers derived from the data-bus width.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      RESP
   } wr_state_t;

   localparam int unsigned AXI_LEN_W = 8;

   function automatic int unsigned strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Largest legal awsize: log2 of the bus width in bytes.
   function automatic int unsigned max_size(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat byte address for FIXED / INCR / WRAP bursts.
// Reserved burst type advances like INCR.
module axi_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]    addr,
   input  logic [2:0]           size,
   input  logic [AXI_LEN_W-1:0] len,
   input  burst_t               burst,
   output logic [ADDR_W-1:0]    next_addr
);

   logic [ADDR_W-1:0] bytes;
   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] wrap_mask;

   always_comb begin
      bytes     = ADDR_W'(1) << size;
      incr      = addr + bytes;
      // Window is (len+1)*bytes; legal wrap lengths make this a power of two.
      wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      unique case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default:     next_addr = incr;
      endcase
   end

endmodule

// File: rtl/axi_write.sv
// AXI4 write-channel slave in front of the DDR backend: one burst at a time, beats are
// forwarded with zero added latency and a single B response closes each burst.
//
// state | meaning
// IDLE  | awready high, waiting for a write address
// DATA  | forwarding W beats to the backend until beat_cnt == awlen
// RESP  | bvalid high until the master takes the response
module axi_write
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                mem_wr_valid,
   input  logic                mem_wr_ready,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [DATA_W-1:0]   mem_wr_data,
   output logic [DATA_W/8-1:0] mem_wr_strb,
   output logic                mem_wr_last
);

   localparam int MAX_SIZE = int'(max_size(DATA_W));

   wr_state_t         state, state_nxt;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [7:0]        len_q;
   logic [2:0]        size_q;
   burst_t            burst_q;
   logic [7:0]        beat_cnt;
   logic              err_q;

   logic aw_xfer, beat_xfer, last_beat, aw_err;

   assign aw_xfer   = awvalid & awready;
   assign beat_xfer = wvalid & wready;
   assign last_beat = (beat_cnt == len_q);

   assign aw_err = (awsize > 3'(MAX_SIZE))
                 | (awburst == BURST_RSVD)
                 | ((awburst == BURST_WRAP) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

   axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (addr_nxt)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      awready      = 1'b0;
      wready       = 1'b0;
      bvalid       = 1'b0;
      mem_wr_valid = 1'b0;
      unique case (state)
         IDLE: begin
            awready = 1'b1;
            if (awvalid) state_nxt = DATA;
         end
         DATA: begin
            wready       = mem_wr_ready;
            mem_wr_valid = wvalid;
            if (wvalid && mem_wr_ready && last_beat) state_nxt = RESP;
         end
         RESP: begin
            bvalid = 1'b1;
            if (bready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= BURST_FIXED;
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else if (aw_xfer) begin
         id_q     <= awid;
         addr_q   <= awaddr;
         len_q    <= awlen;
         size_q   <= awsize;
         burst_q  <= burst_t'(awburst);
         beat_cnt <= '0;
         err_q    <= aw_err;
      end else if (beat_xfer) begin
         beat_cnt <= beat_cnt + 8'd1;
         addr_q   <= addr_nxt;
         // A misplaced wlast only flags the burst; all beats are still forwarded.
         if (wlast != last_beat) err_q <= 1'b1;
      end
   end

   assign mem_wr_addr = addr_q;
   assign mem_wr_data = wdata;
   assign mem_wr_strb = wstrb;
   assign mem_wr_last = (state == DATA) && last_beat;
   assign bid         = id_q;
   assign bresp       = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_write.sv
// Randomized and directed bursts against a burst-level reference model of the write slave.
module tb_axi_write;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        awvalid, awready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        mem_wr_valid, mem_wr_ready;
   logic [31:0] mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic [7:0]  mem_wr_strb;
   logic        mem_wr_last;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_write #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
      .clk(clk), .n_rst(n_rst),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_wr_last(mem_wr_last)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Beat address from the burst rules: offset i*bytes, folded into the wrap window.
   function automatic logic [31:0] exp_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int i);
      logic [31:0] bytes, win, base;
      bytes = 32'(1) << size;
      if (burst == 2'b00) return start;
      if (burst == 2'b10) begin
         win  = (32'(len) + 32'd1) * bytes;
         base = (start / win) * win;
         return base + ((start - base) + 32'(i) * bytes) % win;
      end
      return start + 32'(i) * bytes;
   endfunction

   // bp_mode: 0 backend always ready, 1 ready toggles each cycle, 2 random.
   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                            input int bp_mode, input int bready_dly, input int rst_after);
      int  beat = 0;
      int  cyc  = 0;
      bit  exp_err;
      logic mwr;
      exp_err = (size > 3) || (burst == 2'b11) ||
                (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                (bad_beat >= 0 && bad_beat <= int'(len));

      @(negedge clk);
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      bready = 1'b0; wvalid = 1'b0;
      #1;
      chk("aw_ready_idle", awready, 1'b1);
      chk("idle_no_wready", wready, 1'b0);

      while (beat <= int'(len) && cyc < 400) begin
         @(negedge clk);
         awvalid = 1'b0;
         cyc++;
         if (rst_after >= 0 && beat == rst_after) begin
            n_rst = 1'b0; wvalid = 1'b1; mem_wr_ready = 1'b1;
            #1;
            chk("rst_bvalid", bvalid, 1'b0);
            chk("rst_wready", wready, 1'b0);
            chk("rst_awready", awready, 1'b1);
            chk("rst_memvalid", mem_wr_valid, 1'b0);
            repeat (2) @(negedge clk);
            n_rst = 1'b1; wvalid = 1'b0;
            return;
         end
         case (bp_mode)
            0: mwr = 1'b1;
            1: mwr = (cyc % 2 == 1);
            default: mwr = ($urandom_range(0, 3) != 0);
         endcase
         mem_wr_ready = mwr;
         wvalid = (bp_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         wdata  = {$urandom, $urandom};
         wstrb  = 8'($urandom);
         wlast  = (beat == int'(len)) ^ (beat == bad_beat);
         #1;
         chk("wready_mirror", wready, mwr);
         chk("memvalid_mirror", mem_wr_valid, wvalid);
         chk("data_no_bvalid", bvalid, 1'b0);
         chk("data_no_awready", awready, 1'b0);
         if (wvalid && mwr) begin
            chk("beat_addr", mem_wr_addr, exp_addr(addr, size, len, burst, beat));
            chk("beat_data", mem_wr_data, wdata);
            chk("beat_strb", mem_wr_strb, wstrb);
            chk("beat_last", mem_wr_last, beat == int'(len));
            beat++;
         end
      end
      if (beat <= int'(len)) chk("data_timeout", 1'b1, 1'b0);

      for (int k = 0; k < bready_dly; k++) begin
         @(negedge clk);
         wvalid = 1'b0; bready = 1'b0;
         #1;
         chk("resp_hold_bvalid", bvalid, 1'b1);
         chk("resp_hold_awready", awready, 1'b0);
         chk("resp_hold_wready", wready, 1'b0);
      end
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      #1;
      chk("bvalid", bvalid, 1'b1);
      chk("bid", bid, id);
      chk("bresp", bresp, exp_err ? 2'b10 : 2'b00);
      @(negedge clk);
      bready = 1'b0;
      #1;
      chk("post_bvalid", bvalid, 1'b0);
      chk("post_awready", awready, 1'b1);
   endtask

   initial begin
      logic [1:0] rb;
      logic [7:0] rl;
      n_rst = 1'b0; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
      awburst = '0; wvalid = 1'b1; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
      mem_wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_awready", awready, 1'b1);
      chk("reset_wready", wready, 1'b0);
      chk("reset_bvalid", bvalid, 1'b0);
      chk("reset_memvalid", mem_wr_valid, 1'b0);
      @(negedge clk);
      n_rst = 1'b1; wvalid = 1'b0;

      run_burst(4'd5, 32'h1000, 8'd3, 3'd3, 2'b01, -1, 0, 0, -1);
      run_burst(4'd2, 32'h1018, 8'd3, 3'd3, 2'b10, -1, 0, 0, -1);
      run_burst(4'd7, 32'h2000, 8'd7, 3'd3, 2'b01, -1, 1, 3, -1);
      run_burst(4'd1, 32'h3000, 8'd3, 3'd3, 2'b01,  1, 0, 0, -1);
      run_burst(4'd3, 32'h4000, 8'd2, 3'd3, 2'b11, -1, 0, 1, -1);
      run_burst(4'd4, 32'h5000, 8'd1, 3'd4, 2'b01, -1, 0, 0, -1);
      run_burst(4'd6, 32'h6000, 8'd3, 3'd3, 2'b01, -1, 0, 0,  2);
      run_burst(4'd9, 32'h7000, 8'd3, 3'd3, 2'b01, -1, 0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         rb = 2'($urandom_range(0, 3));
         if (rb == 2'b10) begin
            case ($urandom_range(0, 3))
               0: rl = 8'd1;
               1: rl = 8'd3;
               2: rl = 8'd7;
               default: rl = 8'd15;
            endcase
         end else begin
            rl = 8'($urandom_range(0, 15));
         end
         run_burst(4'($urandom), $urandom, rl, 3'($urandom_range(0, 3)), rb,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1,
                   2, $urandom_range(0, 2), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
